// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage (with cpu_defs_pkg)
// Description : Pipeline MEM stage; passes ALU results through and performs
//               loads/stores over a valid/ready data-cache interface.
// Revision    : 1.0 - initial release
// ============================================================================

package cpu_defs_pkg;
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
endpackage

module mem_stage
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [3:0]        rd_in,
    input  logic [3:0]        op_in,
    input  logic [ADDR_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              in_ready,
    output logic              dmem_req_valid,
    input  logic              dmem_req_ready,
    output logic              dmem_req_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_resp_valid,
    input  logic [DATA_W-1:0] dmem_resp_rdata,
    output logic              wb_valid,
    output logic [3:0]        wb_rd,
    output logic              wb_en,
    output logic [DATA_W-1:0] wb_data,
    output logic              err_misalign,
    output logic              err_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_we;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_wb_valid;
    logic              r_wb_en;
    logic [3:0]        r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_err_misalign;
    logic              r_err_timeout;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_wb_valid;
    logic              w_wb_en;
    logic [3:0]        w_wb_rd;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_set_misalign;
    logic              w_set_timeout;

    assign w_accept = valid_in && (r_state == S_IDLE);
    assign w_is_mem = mem_read || mem_write;

    always_comb begin
        w_next         = r_state;
        w_wb_valid     = 1'b0;
        w_wb_en        = 1'b0;
        w_wb_rd        = r_rd;
        w_wb_data      = '0;
        w_set_misalign = 1'b0;
        w_set_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (valid_in) begin
                    w_wb_rd = rd_in;
                    if (w_is_mem) begin
                        if (alu_result[1:0] != 2'b00) begin
                            w_set_misalign = 1'b1;
                            w_wb_valid     = 1'b1;
                        end else begin
                            w_next = S_REQ;
                        end
                    end else begin
                        w_wb_valid = 1'b1;
                        if (op_in == OP_ADD || op_in == OP_ADDI) begin
                            w_wb_en   = 1'b1;
                            w_wb_data = DATA_W'(alu_result);
                        end
                    end
                end
            end
            S_REQ: begin
                if (dmem_req_ready) begin
                    if (r_we) begin
                        w_next     = S_IDLE;
                        w_wb_valid = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // A response arriving on the final counted cycle still wins.
                if (dmem_resp_valid) begin
                    w_next     = S_IDLE;
                    w_wb_valid = 1'b1;
                    w_wb_en    = 1'b1;
                    w_wb_data  = dmem_resp_rdata;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_next        = S_IDLE;
                    w_wb_valid    = 1'b1;
                    w_set_timeout = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rd    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_rd    <= rd_in;
                r_addr  <= alu_result;
                r_wdata <= store_data;
                r_we    <= mem_write;
            end
            if (r_state == S_REQ) begin
                r_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_valid     <= 1'b0;
            r_wb_en        <= 1'b0;
            r_wb_rd        <= '0;
            r_wb_data      <= '0;
            r_err_misalign <= 1'b0;
            r_err_timeout  <= 1'b0;
        end else begin
            r_wb_valid <= w_wb_valid;
            r_wb_en    <= w_wb_en;
            if (w_wb_valid) begin
                r_wb_rd   <= w_wb_rd;
                r_wb_data <= w_wb_data;
            end
            if (w_set_misalign) r_err_misalign <= 1'b1;
            if (w_set_timeout)  r_err_timeout  <= 1'b1;
        end
    end

    assign in_ready       = (r_state == S_IDLE);
    assign dmem_req_valid = (r_state == S_REQ);
    assign dmem_req_we    = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_wdata     = r_wdata;
    assign wb_valid       = r_wb_valid;
    assign wb_en          = r_wb_en;
    assign wb_rd          = r_wb_rd;
    assign wb_data        = r_wb_data;
    assign err_misalign   = r_err_misalign;
    assign err_timeout    = r_err_timeout;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Self-checking bench for mem_stage: vector table, directed
//               multi-cycle sequences and randomized traffic vs. a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import cpu_defs_pkg::*;

    localparam int c_TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [3:0]  rd_in = '0;
    logic [3:0]  op_in = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        in_ready;
    logic        dmem_req_valid;
    logic        dmem_req_ready = 1'b0;
    logic        dmem_req_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_resp_valid = 1'b0;
    logic [31:0] dmem_resp_rdata = '0;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic        wb_en;
    logic [31:0] wb_data;
    logic        err_misalign;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    mem_stage #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(c_TO)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .rd_in(rd_in), .op_in(op_in),
        .alu_result(alu_result), .store_data(store_data), .mem_read(mem_read),
        .mem_write(mem_write), .in_ready(in_ready), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_rdata(dmem_resp_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_en(wb_en), .wb_data(wb_data), .err_misalign(err_misalign),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  op;
        logic [31:0] alu;
        logic        mr;
        logic        mw;
        logic        en;
        logic [31:0] data;
        logic        mis;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drive(input logic [3:0] rd, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] sd, input logic mr, input logic mw);
        valid_in = 1'b1; rd_in = rd; op_in = op; alu_result = a;
        store_data = sd; mem_read = mr; mem_write = mw;
    endtask

    // Transaction-level model state for the random phase
    logic        m_pend, m_hs, m_we, m_wbv, m_wben, m_mis, m_to;
    logic [3:0]  m_rd, m_wbrd;
    logic [31:0] m_addr, m_wdata, m_wbdata;
    int          m_waited;

    initial begin
        vt[0] = '{rd: 4'd3, op: OP_ADD,   alu: 32'h10,       mr: 0, mw: 0, en: 1, data: 32'h10,       mis: 0};
        vt[1] = '{rd: 4'd7, op: OP_ADDI,  alu: 32'hFFFFFFFF, mr: 0, mw: 0, en: 1, data: 32'hFFFFFFFF, mis: 0};
        vt[2] = '{rd: 4'd1, op: OP_ADD,   alu: 32'h1234,     mr: 0, mw: 0, en: 1, data: 32'h1234,     mis: 0};
        vt[3] = '{rd: 4'd2, op: 4'hA,     alu: 32'h55,       mr: 0, mw: 0, en: 0, data: 32'h0,        mis: 0};
        vt[4] = '{rd: 4'd8, op: OP_LOAD,  alu: 32'h200,      mr: 0, mw: 0, en: 0, data: 32'h0,        mis: 0};
        vt[5] = '{rd: 4'd9, op: OP_STORE, alu: 32'h21,       mr: 0, mw: 1, en: 0, data: 32'h0,        mis: 1};
        vt[6] = '{rd: 4'd5, op: OP_LOAD,  alu: 32'h102,      mr: 1, mw: 0, en: 0, data: 32'h0,        mis: 1};

        // Reset values, checked while reset is still asserted
        idle_inputs();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_req_valid", dmem_req_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_err_mis", err_misalign, 0);
        chk("rst_err_to", err_timeout, 0);
        rst = 1'b0;

        // Single-cycle bundles applied back to back
        for (int i = 0; i < 7; i++) begin
            drive(vt[i].rd, vt[i].op, vt[i].alu, 32'hA5A5, vt[i].mr, vt[i].mw);
            step();
            chk($sformatf("vec%0d_wb_valid", i), wb_valid, 1);
            chk($sformatf("vec%0d_wb_en", i), wb_en, vt[i].en);
            chk($sformatf("vec%0d_wb_rd", i), wb_rd, vt[i].rd);
            if (vt[i].en) chk($sformatf("vec%0d_wb_data", i), wb_data, vt[i].data);
            chk($sformatf("vec%0d_mis", i), err_misalign, vt[i].mis);
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1);
            chk($sformatf("vec%0d_no_req", i), dmem_req_valid, 0);
        end
        idle_inputs();
        step();
        chk("vec_wb_drop", wb_valid, 0);
        chk("vec_mis_sticky", err_misalign, 1);

        // Load with two request stalls and a response three cycles after handshake
        do_reset();
        drive(4'd5, OP_LOAD, 32'h100, 32'h0, 1, 0);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("ld_req_valid", dmem_req_valid, 1);
            chk("ld_req_addr", dmem_addr, 32'h100);
            chk("ld_req_we", dmem_req_we, 0);
            chk("ld_in_ready", in_ready, 0);
            dmem_req_ready = (i == 2);
            step();
        end
        dmem_req_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("ld_wait_req", dmem_req_valid, 0);
            chk("ld_wait_ready", in_ready, 0);
            chk("ld_wait_wb", wb_valid, 0);
            dmem_resp_valid = (j == 2);
            dmem_resp_rdata = 32'hDEADBEEF;
            step();
        end
        dmem_resp_valid = 1'b0;
        chk("ld_wb_valid", wb_valid, 1);
        chk("ld_wb_en", wb_en, 1);
        chk("ld_wb_rd", wb_rd, 5);
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_in_ready", in_ready, 1);
        step();
        chk("ld_wb_once", wb_valid, 0);

        // Store accepted immediately by the cache
        drive(4'd9, OP_STORE, 32'h20, 32'hCAFE, 0, 1);
        dmem_req_ready = 1'b1;
        step();
        valid_in = 1'b0;
        chk("st_req_valid", dmem_req_valid, 1);
        chk("st_req_we", dmem_req_we, 1);
        chk("st_req_addr", dmem_addr, 32'h20);
        chk("st_req_wdata", dmem_wdata, 32'hCAFE);
        step();
        idle_inputs();
        chk("st_req_done", dmem_req_valid, 0);
        chk("st_wb_valid", wb_valid, 1);
        chk("st_wb_en", wb_en, 0);
        chk("st_wb_rd", wb_rd, 9);
        chk("st_in_ready", in_ready, 1);

        // Load that never gets a response, then a spurious response
        drive(4'd4, OP_LOAD, 32'h40, 32'h0, 1, 0);
        dmem_req_ready = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        idle_inputs();
        for (int k = 0; k < c_TO; k++) begin
            chk("to_wait_ready", in_ready, 0);
            chk("to_wait_err", err_timeout, 0);
            chk("to_wait_wb", wb_valid, 0);
            step();
        end
        chk("to_err", err_timeout, 1);
        chk("to_wb_valid", wb_valid, 1);
        chk("to_wb_en", wb_en, 0);
        chk("to_wb_rd", wb_rd, 4);
        chk("to_in_ready", in_ready, 1);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h12345678;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("spur_wb", wb_valid, 0);
            chk("spur_err_sticky", err_timeout, 1);
        end
        dmem_resp_valid = 1'b0;

        // Reset asserted during REQ and during WAIT_RESP
        drive(4'd6, OP_LOAD, 32'h80, 32'h0, 1, 0);
        step();
        valid_in = 1'b0;
        chk("rq_req_valid", dmem_req_valid, 1);
        rst = 1'b1;
        #1;
        chk("rq_rst_req", dmem_req_valid, 0);
        chk("rq_rst_ready", in_ready, 1);
        chk("rq_rst_err", err_timeout, 0);
        step();
        rst = 1'b0;
        drive(4'd6, OP_LOAD, 32'h80, 32'h0, 1, 0);
        dmem_req_ready = 1'b1;
        step();
        valid_in = 1'b0;
        step();
        dmem_req_ready = 1'b0;
        step();
        chk("rw_in_wait", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("rw_rst_req", dmem_req_valid, 0);
        chk("rw_rst_wb", wb_valid, 0);
        chk("rw_rst_ready", in_ready, 1);
        step();
        rst = 1'b0;
        drive(4'd6, OP_LOAD, 32'h84, 32'h0, 1, 0);
        dmem_req_ready = 1'b1;
        step();
        valid_in = 1'b0;
        chk("rl_req_valid", dmem_req_valid, 1);
        chk("rl_req_addr", dmem_addr, 32'h84);
        step();
        dmem_req_ready = 1'b0;
        chk("rl_wait_wb", wb_valid, 0);
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'h55AA;
        step();
        dmem_resp_valid = 1'b0;
        chk("rl_wb_valid", wb_valid, 1);
        chk("rl_wb_en", wb_en, 1);
        chk("rl_wb_rd", wb_rd, 6);
        chk("rl_wb_data", wb_data, 32'h55AA);

        // Randomized traffic against the transaction model
        do_reset();
        m_pend = 0; m_hs = 0; m_we = 0; m_wbv = 0; m_wben = 0; m_mis = 0; m_to = 0;
        m_rd = '0; m_wbrd = '0; m_addr = '0; m_wdata = '0; m_wbdata = '0; m_waited = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_in_ready", in_ready, !m_pend);
            chk("rnd_req_valid", dmem_req_valid, m_pend && !m_hs);
            if (m_pend && !m_hs) begin
                chk("rnd_req_addr", dmem_addr, m_addr);
                chk("rnd_req_we", dmem_req_we, m_we);
                if (m_we) chk("rnd_req_wdata", dmem_wdata, m_wdata);
            end
            chk("rnd_wb_valid", wb_valid, m_wbv);
            if (m_wbv) begin
                chk("rnd_wb_rd", wb_rd, m_wbrd);
                chk("rnd_wb_en", wb_en, m_wben);
                if (m_wben) chk("rnd_wb_data", wb_data, m_wbdata);
            end
            chk("rnd_err_mis", err_misalign, m_mis);
            chk("rnd_err_to", err_timeout, m_to);

            valid_in        = ($urandom_range(0, 9) < 7);
            rd_in           = 4'($urandom);
            op_in           = 4'($urandom_range(0, 5));
            alu_result      = $urandom;
            if ($urandom_range(0, 4) != 0) alu_result[1:0] = 2'b00;
            store_data      = $urandom;
            mem_read        = ($urandom_range(0, 2) == 0);
            mem_write       = ($urandom_range(0, 2) == 0);
            dmem_req_ready  = ($urandom_range(0, 9) < 6);
            dmem_resp_valid = ($urandom_range(0, 9) < 4);
            dmem_resp_rdata = $urandom;

            m_wbv = 0;
            if (!m_pend) begin
                if (valid_in) begin
                    m_wbrd = rd_in;
                    if (mem_read || mem_write) begin
                        if (alu_result[1:0] != 2'b00) begin
                            m_mis = 1; m_wbv = 1; m_wben = 0;
                        end else begin
                            m_pend = 1; m_hs = 0; m_rd = rd_in; m_addr = alu_result;
                            m_wdata = store_data; m_we = mem_write;
                        end
                    end else begin
                        m_wbv = 1;
                        m_wben = (op_in == OP_ADD || op_in == OP_ADDI);
                        m_wbdata = alu_result;
                    end
                end
            end else if (!m_hs) begin
                if (dmem_req_ready) begin
                    if (m_we) begin
                        m_pend = 0; m_wbv = 1; m_wben = 0; m_wbrd = m_rd;
                    end else begin
                        m_hs = 1; m_waited = 0;
                    end
                end
            end else begin
                m_waited++;
                if (dmem_resp_valid) begin
                    m_pend = 0; m_wbv = 1; m_wben = 1; m_wbrd = m_rd; m_wbdata = dmem_resp_rdata;
                end else if (m_waited == c_TO) begin
                    m_pend = 0; m_wbv = 1; m_wben = 0; m_wbrd = m_rd; m_to = 1;
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
